// File: rtl/btn_conditioner.sv
// btn_conditioner: four-channel push-button front end.
// Each raw level is synchronised, debounced and turned into clean one-cycle
// press / release / auto-repeat pulses. A chord event fires when the number
// of held buttons rises from one or fewer to two or more.
module btn_conditioner #(
    parameter int NUM_BTN       = 4,
    parameter int DB_CYCLES     = 250000,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_state,
    output logic [NUM_BTN-1:0] btn_pulse,
    output logic [NUM_BTN-1:0] btn_release,
    output logic               chord_pulse,
    output logic [NUM_BTN-1:0] chord_code
);

    localparam int DB_W   = $clog2(DB_CYCLES);
    localparam int RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RC_W   = $clog2(RC_MAX);
    localparam int POP_W  = $clog2(NUM_BTN + 1);

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DB_CYCLES - 1);
    localparam logic [RC_W-1:0]  DELAY_LAST  = RC_W'(REPEAT_DELAY - 1);
    localparam logic [RC_W-1:0]  PERIOD_LAST = RC_W'(REPEAT_PERIOD - 1);
    localparam logic [POP_W-1:0] POP_ONE     = POP_W'(1);
    localparam logic [POP_W-1:0] POP_TWO     = POP_W'(2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RPT  = 2'd2
    } rpt_state_e;

    // Number of set bits in a button vector.
    function automatic logic [POP_W-1:0] popcount(input logic [NUM_BTN-1:0] v);
        logic [POP_W-1:0] acc;
        acc = {POP_W{1'b0}};
        for (int k = 0; k < NUM_BTN; k++) begin
            acc = acc + POP_W'(v[k]);
        end
        return acc;
    endfunction

    logic [NUM_BTN-1:0] s1_q, s2_q;
    logic [NUM_BTN-1:0] state_q, state_d;
    logic [NUM_BTN-1:0] pulse_q, pulse_d;
    logic [NUM_BTN-1:0] release_q;
    logic [NUM_BTN-1:0] press_s, release_s, rpt_s;
    logic [DB_W-1:0]    db_cnt_q [NUM_BTN];
    logic [DB_W-1:0]    db_cnt_d [NUM_BTN];
    rpt_state_e         rpt_st_q [NUM_BTN];
    rpt_state_e         rpt_st_d [NUM_BTN];
    logic [RC_W-1:0]    rc_q     [NUM_BTN];
    logic [RC_W-1:0]    rc_d     [NUM_BTN];
    logic [POP_W-1:0]   pop_q, pop_d;
    logic               chord_q, chord_d;
    logic [NUM_BTN-1:0] code_q, code_d;

    // Two-stage synchroniser for the asynchronous button levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= {NUM_BTN{1'b0}};
            s2_q <= {NUM_BTN{1'b0}};
        end else begin
            s1_q <= btn_in;
            s2_q <= s1_q;
        end
    end

    // Debounce: accept a new level only after DB_CYCLES stable samples.
    always_comb begin
        state_d   = state_q;
        press_s   = {NUM_BTN{1'b0}};
        release_s = {NUM_BTN{1'b0}};
        for (int i = 0; i < NUM_BTN; i++) begin
            db_cnt_d[i] = db_cnt_q[i];
            if (s2_q[i] == state_q[i]) begin
                db_cnt_d[i] = {DB_W{1'b0}};
            end else if (db_cnt_q[i] == DB_LAST) begin
                state_d[i]  = s2_q[i];
                db_cnt_d[i] = {DB_W{1'b0}};
                if (s2_q[i]) begin
                    press_s[i] = 1'b1;
                end else begin
                    release_s[i] = 1'b1;
                end
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
        end
    end

    // Auto-repeat FSM: first repeat after REPEAT_DELAY, then every REPEAT_PERIOD.
    // An accepted release wins over a repeat landing in the same cycle.
    always_comb begin
        rpt_s = {NUM_BTN{1'b0}};
        for (int i = 0; i < NUM_BTN; i++) begin
            rpt_st_d[i] = rpt_st_q[i];
            rc_d[i]     = rc_q[i];
            case (rpt_st_q[i])
                ST_IDLE: begin
                    if ((REPEAT_EN != 0) && press_s[i]) begin
                        rpt_st_d[i] = ST_HOLD;
                        rc_d[i]     = {RC_W{1'b0}};
                    end else begin
                        rpt_st_d[i] = ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (release_s[i]) begin
                        rpt_st_d[i] = ST_IDLE;
                        rc_d[i]     = {RC_W{1'b0}};
                    end else if (rc_q[i] == DELAY_LAST) begin
                        rpt_s[i]    = 1'b1;
                        rpt_st_d[i] = ST_RPT;
                        rc_d[i]     = {RC_W{1'b0}};
                    end else begin
                        rc_d[i] = rc_q[i] + RC_W'(1);
                    end
                end
                ST_RPT: begin
                    if (release_s[i]) begin
                        rpt_st_d[i] = ST_IDLE;
                        rc_d[i]     = {RC_W{1'b0}};
                    end else if (rc_q[i] == PERIOD_LAST) begin
                        rpt_s[i] = 1'b1;
                        rc_d[i]  = {RC_W{1'b0}};
                    end else begin
                        rc_d[i] = rc_q[i] + RC_W'(1);
                    end
                end
                default: begin
                    rpt_st_d[i] = ST_IDLE;
                    rc_d[i]     = {RC_W{1'b0}};
                end
            endcase
        end
    end

    // Output pulse merge and chord detection on the next debounced state.
    always_comb begin
        pulse_d = press_s | rpt_s;
        pop_d   = popcount(state_d);
        chord_d = (pop_q <= POP_ONE) && (pop_d >= POP_TWO);
        if (chord_d) begin
            code_d = state_d;
        end else begin
            code_d = code_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= {NUM_BTN{1'b0}};
            pulse_q   <= {NUM_BTN{1'b0}};
            release_q <= {NUM_BTN{1'b0}};
            pop_q     <= {POP_W{1'b0}};
            chord_q   <= 1'b0;
            code_q    <= {NUM_BTN{1'b0}};
            for (int i = 0; i < NUM_BTN; i++) begin
                db_cnt_q[i] <= {DB_W{1'b0}};
                rpt_st_q[i] <= ST_IDLE;
                rc_q[i]     <= {RC_W{1'b0}};
            end
        end else begin
            state_q   <= state_d;
            pulse_q   <= pulse_d;
            release_q <= release_s;
            pop_q     <= pop_d;
            chord_q   <= chord_d;
            code_q    <= code_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
                rpt_st_q[i] <= rpt_st_d[i];
                rc_q[i]     <= rc_d[i];
            end
        end
    end

    assign btn_state   = state_q;
    assign btn_pulse   = pulse_q;
    assign btn_release = release_q;
    assign chord_pulse = chord_q;
    assign chord_code  = code_q;

endmodule
